dpi_stream_sequencer: RTL and testbench

//  Upstream feeder for the per-regex DPI matcher wrappers. Accepts a framed byte stream

---
 rtl/dpi_stream_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_dpi_stream_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_stream_sequencer.sv
// Front end for the per-regex DPI matchers: maps flow keys to tagged stream ids and
// sequences load_state / payload chars / drain / eop around each packet.
module dpi_stream_sequencer #(
   parameter int NUM_REGEX = 8,
   parameter int KEY_W     = 16,
   parameter int LOAD_GAP  = 2,
   parameter int EOP_DELAY = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_vld,
   output logic                 in_ready,
   input  logic [7:0]           in_data,
   input  logic                 in_sop,
   input  logic                 in_eop,
   input  logic [KEY_W-1:0]     in_flow_key,
   input  logic                 cfg_we,
   input  logic [5:0]           cfg_addr,
   input  logic [NUM_REGEX-1:0] cfg_mask,
   output logic                 load_state,
   output logic [5:0]           stream_id,
   output logic                 new_stream_id,
   output logic [7:0]           char_in,
   output logic                 char_in_vld,
   output logic                 eop,
   output logic [NUM_REGEX-1:0] enable,
   output logic [15:0]          pkt_count,
   output logic [15:0]          err_count
);

   localparam int TAG_W = KEY_W - 6;
   localparam logic [7:0] GAP_LAST   = 8'(LOAD_GAP - 1);
   localparam logic [7:0] DRAIN_LAST = 8'(EOP_DELAY);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_LOAD, S_GAP, S_STREAM, S_DRAIN, S_EOP
   } state_t;

   state_t               state_q;
   logic [KEY_W-1:0]     key_q;
   logic [7:0]           byte_q;
   logic                 last_q;
   logic [7:0]           cnt_q;
   logic [63:0]          valid_q;
   logic [TAG_W-1:0]     tag_q  [64];
   logic [NUM_REGEX-1:0] mask_q [64];

   logic                 in_ready_q;
   logic                 load_state_q;
   logic [5:0]           stream_id_q;
   logic                 new_q;
   logic [7:0]           char_q;
   logic                 char_vld_q;
   logic                 eop_q;
   logic [NUM_REGEX-1:0] enable_q;
   logic [15:0]          pkt_q;
   logic [15:0]          err_q;

   logic                 accept;
   logic                 emit_first;
   logic [15:0]          err_count_d;

   always_comb begin
      accept      = in_vld && in_ready_q;
      err_count_d = (err_q == '1) ? err_q : err_q + 16'd1;
      emit_first  = 1'b0;
      if (state_q == S_LOAD && LOAD_GAP <= 1)
         emit_first = 1'b1;
      else if (state_q == S_GAP && cnt_q == GAP_LAST)
         emit_first = 1'b1;
   end

   // Reading the mask at the LOOKUP edge means a same-cycle cfg write is not yet visible.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 64; i++)
            mask_q[i] <= '0;
      end else if (cfg_we) begin
         mask_q[cfg_addr] <= cfg_mask;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && state_q == S_LOAD && new_q)
         tag_q[stream_id_q] <= key_q[KEY_W-1:6];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         key_q        <= '0;
         byte_q       <= '0;
         last_q       <= 1'b0;
         cnt_q        <= '0;
         valid_q      <= '0;
         in_ready_q   <= 1'b1;
         load_state_q <= 1'b0;
         stream_id_q  <= '0;
         new_q        <= 1'b0;
         char_q       <= '0;
         char_vld_q   <= 1'b0;
         eop_q        <= 1'b0;
         enable_q     <= '0;
         pkt_q        <= '0;
         err_q        <= '0;
      end else begin
         load_state_q <= 1'b0;
         char_vld_q   <= 1'b0;
         eop_q        <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (in_sop) begin
                     key_q      <= in_flow_key;
                     byte_q     <= in_data;
                     last_q     <= in_eop;
                     in_ready_q <= 1'b0;
                     state_q    <= S_LOOKUP;
                  end else begin
                     err_q <= err_count_d;
                  end
               end
            end
            S_LOOKUP: begin
               load_state_q <= 1'b1;
               stream_id_q  <= key_q[5:0];
               new_q        <= !valid_q[key_q[5:0]] ||
                               (tag_q[key_q[5:0]] != key_q[KEY_W-1:6]);
               enable_q     <= mask_q[key_q[5:0]];
               state_q      <= S_LOAD;
            end
            S_LOAD: begin
               if (new_q)
                  valid_q[stream_id_q] <= 1'b1;
               if (!emit_first) begin
                  cnt_q   <= 8'd1;
                  state_q <= S_GAP;
               end
            end
            S_GAP: begin
               if (!emit_first)
                  cnt_q <= cnt_q + 8'd1;
            end
            S_STREAM: begin
               if (accept) begin
                  char_q     <= in_data;
                  char_vld_q <= 1'b1;
                  if (in_sop)
                     err_q <= err_count_d;
                  if (in_eop) begin
                     in_ready_q <= 1'b0;
                     cnt_q      <= 8'd1;
                     state_q    <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               // The cycle showing the last char counts as the first drain cycle.
               if (cnt_q == DRAIN_LAST) begin
                  eop_q   <= 1'b1;
                  pkt_q   <= pkt_q + 16'd1;
                  state_q <= S_EOP;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_EOP: begin
               in_ready_q <= 1'b1;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase

         if (emit_first) begin
            char_q     <= byte_q;
            char_vld_q <= 1'b1;
            if (last_q) begin
               cnt_q   <= 8'd1;
               state_q <= S_DRAIN;
            end else begin
               in_ready_q <= 1'b1;
               state_q    <= S_STREAM;
            end
         end
      end
   end

   assign in_ready      = in_ready_q;
   assign load_state    = load_state_q;
   assign stream_id     = stream_id_q;
   assign new_stream_id = new_q;
   assign char_in       = char_q;
   assign char_in_vld   = char_vld_q;
   assign eop           = eop_q;
   assign enable        = enable_q;
   assign pkt_count     = pkt_q;
   assign err_count     = err_q;

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed bench for dpi_stream_sequencer: packet sequencing timing, stream table,
// enable masks, error counting and mid-packet reset.
module tb_dpi_stream_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_vld = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = '0;
   logic        in_sop = 1'b0;
   logic        in_eop = 1'b0;
   logic [15:0] in_flow_key = '0;
   logic        cfg_we = 1'b0;
   logic [5:0]  cfg_addr = '0;
   logic [7:0]  cfg_mask = '0;
   logic        load_state;
   logic [5:0]  stream_id;
   logic        new_stream_id;
   logic [7:0]  char_in;
   logic        char_in_vld;
   logic        eop;
   logic [7:0]  enable;
   logic [15:0] pkt_count;
   logic [15:0] err_count;

   int n_checks = 0;
   int n_errors = 0;

   dpi_stream_sequencer #(
      .NUM_REGEX(8), .KEY_W(16), .LOAD_GAP(2), .EOP_DELAY(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_vld(in_vld), .in_ready(in_ready), .in_data(in_data),
      .in_sop(in_sop), .in_eop(in_eop), .in_flow_key(in_flow_key),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask),
      .load_state(load_state), .stream_id(stream_id), .new_stream_id(new_stream_id),
      .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop),
      .enable(enable), .pkt_count(pkt_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Event recorder, sampled on the falling edge.
   int         n_load = 0, n_eop = 0, ld_cyc = 0, eop_cyc = 0, unstable = 0;
   logic [5:0] ld_sid = '0, eop_sid = '0;
   logic       ld_new = 1'b0;
   logic [7:0] ld_en = '0, eop_en = '0;
   logic [7:0] ch_q[$];
   int         chc_q[$];
   bit         in_pkt = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_pkt = 1'b0;
      end else begin
         if (load_state === 1'b1) begin
            n_load++; ld_cyc = cyc; ld_sid = stream_id; ld_new = new_stream_id;
            ld_en = enable; in_pkt = 1'b1;
         end else if (in_pkt && (enable !== ld_en || stream_id !== ld_sid)) begin
            unstable++;
         end
         if (char_in_vld === 1'b1) begin
            ch_q.push_back(char_in); chc_q.push_back(cyc);
         end
         if (eop === 1'b1) begin
            n_eop++; eop_cyc = cyc; eop_sid = stream_id; eop_en = enable; in_pkt = 1'b0;
         end
      end
   end

   task automatic beat(input logic [15:0] key, input logic [7:0] d, input logic sop,
                       input logic last);
      int t = 0;
      in_vld = 1'b1; in_data = d; in_sop = sop; in_eop = last; in_flow_key = key;
      while (in_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      n_checks++;
      if (t >= 50) begin
         n_errors++; $display("FAIL beat_accept ready=%b required=1", in_ready);
      end
      @(negedge clk);
      in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
   endtask

   task automatic send_pkt(input logic [15:0] key, input logic [63:0] data, input int n,
                           input int maxgap);
      for (int i = 0; i < n; i++) begin
         beat(key, data[8*i +: 8], i == 0, i == n - 1);
         if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
      end
   endtask

   task automatic wait_eop(input int base);
      int t = 0;
      while (n_eop == base && t < 100) begin @(negedge clk); #1; t++; end
      n_checks++;
      if (n_eop == base) begin
         n_errors++; $display("FAIL eop_timeout eops=%0d required>%0d", n_eop, base);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_vld = 1'b0; cfg_we = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if ({in_ready, load_state, char_in_vld, eop, new_stream_id} !== 5'b10000) begin
         n_errors++;
         $display("FAIL reset_ctrl got rdy=%b ld=%b cv=%b eop=%b new=%b required 1 0 0 0 0",
                  in_ready, load_state, char_in_vld, eop, new_stream_id);
      end
      n_checks++;
      if ({stream_id, char_in, enable, pkt_count, err_count} !== '0) begin
         n_errors++;
         $display("FAIL reset_data got sid=%0d ch=%h en=%h pkt=%0d err=%0d required all 0",
                  stream_id, char_in, enable, pkt_count, err_count);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int b_eop = n_eop, b_ch = ch_q.size();
      logic [7:0] exp_b;
      send_pkt(16'h0103, 64'h43_42_41, 3, 0);
      wait_eop(b_eop);
      n_checks++;
      if (ld_sid !== 6'd3 || ld_new !== 1'b1) begin
         n_errors++; $display("FAIL basic_load sid=%0d new=%b required sid=3 new=1", ld_sid, ld_new);
      end
      n_checks++;
      if (ch_q.size() != b_ch + 3) begin
         n_errors++; $display("FAIL basic_nchar got=%0d required=3", ch_q.size() - b_ch);
      end else begin
         for (int i = 0; i < 3; i++) begin
            exp_b = 8'h41 + 8'(i);
            n_checks++;
            if (ch_q[b_ch+i] !== exp_b || chc_q[b_ch+i] != ld_cyc + 2 + i) begin
               n_errors++;
               $display("FAIL basic_char%0d got=%h@+%0d required=%h@+%0d", i, ch_q[b_ch+i],
                        chc_q[b_ch+i] - ld_cyc, exp_b, 2 + i);
            end
         end
      end
      n_checks++;
      if (eop_cyc != ld_cyc + 8) begin
         n_errors++; $display("FAIL basic_eop_lat got=%0d required=8", eop_cyc - ld_cyc);
      end
      n_checks++;
      if (pkt_count !== 16'd1) begin
         n_errors++; $display("FAIL basic_pkt got=%0d required=1", pkt_count);
      end
   endtask

   task automatic test_stream_table();
      logic [15:0] keys [3] = '{16'h0103, 16'h0203, 16'h0103};
      logic        exp_new [3] = '{1'b0, 1'b1, 1'b1};
      int b_eop;
      for (int i = 0; i < 3; i++) begin
         b_eop = n_eop;
         send_pkt(keys[i], 64'h10, 1, 0);
         wait_eop(b_eop);
         n_checks++;
         if (ld_sid !== 6'd3 || ld_new !== exp_new[i]) begin
            n_errors++;
            $display("FAIL table_%0d key=%h sid=%0d new=%b required sid=3 new=%b", i, keys[i],
                     ld_sid, ld_new, exp_new[i]);
         end
      end
      n_checks++;
      if (pkt_count !== 16'd4) begin
         n_errors++; $display("FAIL table_pkt got=%0d required=4", pkt_count);
      end
   endtask

   task automatic test_cfg();
      int b_eop = n_eop, b_uns = unstable;
      cfg_we = 1'b1; cfg_addr = 6'd3; cfg_mask = 8'hA5;
      @(negedge clk);
      cfg_we = 1'b0;
      beat(16'h0103, 8'h01, 1'b1, 1'b0);
      beat(16'h0103, 8'h02, 1'b0, 1'b0);
      cfg_we = 1'b1; cfg_mask = 8'h3C;
      beat(16'h0103, 8'h03, 1'b0, 1'b0);
      cfg_we = 1'b0;
      beat(16'h0103, 8'h04, 1'b0, 1'b1);
      wait_eop(b_eop);
      n_checks++;
      if (ld_en !== 8'hA5 || eop_en !== 8'hA5 || eop_sid !== 6'd3) begin
         n_errors++;
         $display("FAIL cfg_enable load=%h eop=%h sid=%0d required A5 A5 3", ld_en, eop_en, eop_sid);
      end
      n_checks++;
      if (unstable != b_uns) begin
         n_errors++; $display("FAIL cfg_stable changes=%0d required=0", unstable - b_uns);
      end
      b_eop = n_eop;
      send_pkt(16'h0103, 64'h09, 1, 0);
      wait_eop(b_eop);
      n_checks++;
      if (ld_en !== 8'h3C) begin
         n_errors++; $display("FAIL cfg_next got=%h required=3C", ld_en);
      end
   endtask

   task automatic test_single_byte();
      int b_eop = n_eop, b_ch = ch_q.size();
      send_pkt(16'h0005, 64'h7E, 1, 0);
      wait_eop(b_eop);
      n_checks++;
      if (ch_q.size() != b_ch + 1) begin
         n_errors++; $display("FAIL single_nchar got=%0d required=1", ch_q.size() - b_ch);
      end else begin
         n_checks++;
         if (ch_q[b_ch] !== 8'h7E || chc_q[b_ch] != ld_cyc + 2 || eop_cyc != chc_q[b_ch] + 4) begin
            n_errors++;
            $display("FAIL single_timing ch=%h ld->ch=%0d ch->eop=%0d required 7E 2 4",
                     ch_q[b_ch], chc_q[b_ch] - ld_cyc, eop_cyc - chc_q[b_ch]);
         end
      end
      n_checks++;
      if (ld_sid !== 6'd5 || ld_new !== 1'b1) begin
         n_errors++; $display("FAIL single_load sid=%0d new=%b required 5 1", ld_sid, ld_new);
      end
   endtask

   task automatic test_errors();
      logic [63:0] data = 64'h66_55_44_33_22_11;
      int b_ld = n_load, b_eop, b_ch;
      beat(16'h0000, 8'h55, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      #1;
      n_checks++;
      if (err_count !== 16'd1 || n_load != b_ld) begin
         n_errors++;
         $display("FAIL nonsop_drop err=%0d loads=%0d required err=1 loads=0", err_count, n_load - b_ld);
      end
      b_eop = n_eop; b_ch = ch_q.size();
      for (int i = 0; i < 6; i++) begin
         beat(16'h0107, data[8*i +: 8], i == 0 || i == 2, i == 5);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_eop(b_eop);
      n_checks++;
      if (ch_q.size() != b_ch + 6) begin
         n_errors++; $display("FAIL gaps_nchar got=%0d required=6", ch_q.size() - b_ch);
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (ch_q[b_ch+i] !== data[8*i +: 8]) begin
               n_errors++;
               $display("FAIL gaps_char%0d got=%h required=%h", i, ch_q[b_ch+i], data[8*i +: 8]);
            end
         end
      end
      n_checks++;
      if (err_count !== 16'd2 || ld_sid !== 6'd7 || ld_new !== 1'b1) begin
         n_errors++;
         $display("FAIL midsop err=%0d sid=%0d new=%b required 2 7 1", err_count, ld_sid, ld_new);
      end
   endtask

   task automatic test_reset_mid();
      int b_eop = n_eop, b_ch;
      beat(16'h0108, 8'hA1, 1'b1, 1'b0);
      beat(16'h0108, 8'hA2, 1'b0, 1'b0);
      beat(16'h0108, 8'hA3, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      n_checks++;
      if ({in_ready, char_in_vld, eop, load_state} !== 4'b1000 ||
          {stream_id, enable, pkt_count, err_count} !== '0) begin
         n_errors++;
         $display("FAIL midrst_out rdy=%b cv=%b eop=%b sid=%0d pkt=%0d err=%0d required 1 0 0 0 0 0",
                  in_ready, char_in_vld, eop, stream_id, pkt_count, err_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      n_checks++;
      if (n_eop != b_eop) begin
         n_errors++; $display("FAIL midrst_noeop eops=%0d required=0", n_eop - b_eop);
      end
      b_ch = ch_q.size();
      send_pkt(16'h0103, 64'hBB_AA, 2, 0);
      wait_eop(b_eop);
      n_checks++;
      if (ld_new !== 1'b1 || ch_q.size() != b_ch + 2 || pkt_count !== 16'd1) begin
         n_errors++;
         $display("FAIL midrst_next new=%b nchar=%0d pkt=%0d required 1 2 1",
                  ld_new, ch_q.size() - b_ch, pkt_count);
      end else begin
         n_checks++;
         if (ch_q[b_ch] !== 8'hAA || ch_q[b_ch+1] !== 8'hBB) begin
            n_errors++;
            $display("FAIL midrst_chars got=%h %h required=AA BB", ch_q[b_ch], ch_q[b_ch+1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stream_table();
      test_cfg();
      test_single_byte();
      test_errors();
      test_reset_mid();
      do_reset();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
